// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-path widths, slot/group types and pop clipping helper
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_slot_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr0;
    logic [XLEN-1:0] instr1;
    logic            valid;
  } fetch_group_t;

  // Decode can take at most two per cycle; an encoded 3 means "as many as possible".
  function automatic logic [1:0] clip_pop(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - fetch-group input, stall/flush and dual decode output bundle
interface fetch_buffer_if;
  import core_pkg::*;

  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr0;
  logic [XLEN-1:0] in_instr1;
  logic            stall_out;
  logic            flush;
  logic [1:0]      pop_cnt;
  logic            out_valid0;
  logic [XLEN-1:0] out_instr0;
  logic [XLEN-1:0] out_pc0;
  logic            out_valid1;
  logic [XLEN-1:0] out_instr1;
  logic [XLEN-1:0] out_pc1;

  // Fetch/decode side: presents groups, redirects and consumption counts
  modport master (
    output in_valid, in_pc, in_instr0, in_instr1, flush, pop_cnt,
    input  stall_out, out_valid0, out_instr0, out_pc0,
           out_valid1, out_instr1, out_pc1
  );

  // Buffer side
  modport slave (
    input  in_valid, in_pc, in_instr0, in_instr1, flush, pop_cnt,
    output stall_out, out_valid0, out_instr0, out_pc0,
           out_valid1, out_instr1, out_pc1
  );

endinterface

// File: rtl/fetch_buffer_ram.sv
// rtl/fetch_buffer_ram.sv - DEPTH x fetch_slot_t storage, two write ports, two async read ports
module fetch_buffer_ram
  import core_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW-1:0] waddr0,
  input  fetch_slot_t wdata0,
  input  logic [AW-1:0] waddr1,
  input  fetch_slot_t wdata1,
  input  logic [AW-1:0] raddr0,
  output fetch_slot_t rdata0,
  input  logic [AW-1:0] raddr1,
  output fetch_slot_t rdata1
);

  fetch_slot_t mem_q [DEPTH];

  // Both halves of a group land together; tail is always even so the addresses never collide
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr0] <= wdata0;
      mem_q[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - dual-issue instruction queue between fetch and decode; FETCH_BUF_STATS_EN adds stall/flush counters
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  fetch_buffer_if.slave fb
`ifdef FETCH_BUF_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_group_t grp;
  fetch_slot_t  wdata0, wdata1, rdata0, rdata1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;
  logic          push;
  logic [1:0]    pop_req;
  logic [CW-1:0] pop_eff;

  assign grp = '{pc: fb.in_pc, instr0: fb.in_instr0, instr1: fb.in_instr1, valid: fb.in_valid};

  assign wdata0 = '{instr: grp.instr0, pc: grp.pc};
  assign wdata1 = '{instr: grp.instr1, pc: grp.pc + XLEN'(INSTR_BYTES)};

  fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we     (push),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .waddr1 (tail_q + AW'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .rdata0 (rdata0),
    .raddr1 (head_q + AW'(1)),
    .rdata1 (rdata1)
  );

  // Next-state for pointers, occupancy and stall; flush wipes everything and drops the group
  always_comb begin
    pop_req = clip_pop(fb.pop_cnt);
    pop_eff = (CW'(pop_req) > count_q) ? count_q : CW'(pop_req);
    push    = grp.valid && !stall_q && !fb.flush;
    head_d  = head_q + AW'(pop_eff);
    tail_d  = push ? tail_q + AW'(2) : tail_q;
    count_d = count_q + (push ? CW'(2) : CW'(0)) - pop_eff;
    if (fb.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    stall_d = (DEPTH_C - count_d) < CW'(2);
  end

  // Queue state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  assign fb.stall_out  = stall_q;
  assign fb.out_valid0 = (count_q != '0);
  assign fb.out_valid1 = (count_q >= CW'(2));
  // Gating keeps never-written storage from leaking onto the outputs
  assign fb.out_instr0 = fb.out_valid0 ? rdata0.instr : '0;
  assign fb.out_pc0    = fb.out_valid0 ? rdata0.pc    : '0;
  assign fb.out_instr1 = fb.out_valid1 ? rdata1.instr : '0;
  assign fb.out_pc1    = fb.out_valid1 ? rdata1.pc    : '0;

`ifdef FETCH_BUF_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fb.in_valid && stall_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (fb.flush && (flush_cnt_q != '1))               flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer with queue model and directed vectors
module tb_fetch_buffer;
  import core_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_buffer_if fb_if ();

`ifdef FETCH_BUF_STATS_EN
  logic [31:0] stat_stall_cycles, stat_flush_count;
`endif

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fb_if.slave)
`ifdef FETCH_BUF_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_flush_count  (stat_flush_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain FIFO of {instr, pc} entries
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_stall;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  always @(posedge clk or negedge reset) begin : model
    int npop;
    bit do_push;
    if (!reset) begin
      mq.delete();
      m_stall     = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (fb_if.in_valid && m_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (fb_if.flush) begin
        if (m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        mq.delete();
        m_stall = 1'b0;
      end else begin
        do_push = fb_if.in_valid && !m_stall;
        npop = (fb_if.pop_cnt == 2'd3) ? 2 : int'(fb_if.pop_cnt);
        if (npop > mq.size()) npop = mq.size();
        repeat (npop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{instr: fb_if.in_instr0, pc: fb_if.in_pc});
          mq.push_back('{instr: fb_if.in_instr1, pc: fb_if.in_pc + 32'd4});
        end
        m_stall = (DEPTH - mq.size()) < 2;
      end
    end
  end

  // Every cycle compare against the model on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_stall", fb_if.stall_out, 0);
      chk("rst_valid0", fb_if.out_valid0, 0);
      chk("rst_valid1", fb_if.out_valid1, 0);
      chk("rst_instr0", fb_if.out_instr0, 0);
      chk("rst_pc0", fb_if.out_pc0, 0);
      chk("rst_instr1", fb_if.out_instr1, 0);
      chk("rst_pc1", fb_if.out_pc1, 0);
    end else begin
      chk("m_stall", fb_if.stall_out, m_stall);
      chk("m_valid0", fb_if.out_valid0, mq.size() >= 1);
      chk("m_valid1", fb_if.out_valid1, mq.size() >= 2);
      if (mq.size() >= 1) begin
        chk("m_instr0", fb_if.out_instr0, mq[0].instr);
        chk("m_pc0", fb_if.out_pc0, mq[0].pc);
      end
      if (mq.size() >= 2) begin
        chk("m_instr1", fb_if.out_instr1, mq[1].instr);
        chk("m_pc1", fb_if.out_pc1, mq[1].pc);
      end
    end
`ifdef FETCH_BUF_STATS_EN
    chk("m_stat_stall", stat_stall_cycles, m_stall_cnt);
    chk("m_stat_flush", stat_flush_count, m_flush_cnt);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic v, input logic [31:0] pc);
    fb_if.in_valid  = v;
    fb_if.in_pc     = pc;
    fb_if.in_instr0 = pc ^ 32'h5A00_0013;
    fb_if.in_instr1 = pc ^ 32'hA500_0093;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    fb_if.in_valid  = 1'b0;
    fb_if.in_pc     = '0;
    fb_if.in_instr0 = '0;
    fb_if.in_instr1 = '0;
    fb_if.flush     = 1'b0;
    fb_if.pop_cnt   = 2'd0;
    #1 reset = 1'b0;
    repeat (2) step();
    chk("reset_valid0", fb_if.out_valid0, 0);
    chk("reset_stall", fb_if.stall_out, 0);
    chk("reset_pc0", fb_if.out_pc0, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("idle_valid0", fb_if.out_valid0, 0);
    chk("idle_valid1", fb_if.out_valid1, 0);

    // Single group, no pop
    fb_if.in_valid  = 1'b1;
    fb_if.in_pc     = 32'h100;
    fb_if.in_instr0 = 32'h00A0_0093;
    fb_if.in_instr1 = 32'h00B0_0113;
    step();
    set_group(1'b0, 32'h0);
    chk("a_pc0", fb_if.out_pc0, 32'h100);
    chk("a_pc1", fb_if.out_pc1, 32'h104);
    chk("a_instr0", fb_if.out_instr0, 32'h00A0_0093);
    chk("a_instr1", fb_if.out_instr1, 32'h00B0_0113);
    chk("a_valid0", fb_if.out_valid0, 1);
    chk("a_valid1", fb_if.out_valid1, 1);
    fb_if.pop_cnt = 2'd2;
    step();
    fb_if.pop_cnt = 2'd0;
    chk("a_drained", fb_if.out_valid0, 0);

    // Fill to full, hold a fifth group under stall, then release
    for (int i = 0; i < 4; i++) begin
      set_group(1'b1, 32'h200 + 32'(8 * i));
      step();
      chk("b_fill_stall", fb_if.stall_out, (i == 3) ? 1 : 0);
    end
    set_group(1'b1, 32'h220);
    repeat (3) begin
      step();
      chk("b_held_stall", fb_if.stall_out, 1);
      chk("b_held_head", fb_if.out_pc0, 32'h200);
    end
    fb_if.pop_cnt = 2'd2;
    step();
    fb_if.pop_cnt = 2'd0;
    chk("b_release_stall", fb_if.stall_out, 0);
    chk("b_release_head", fb_if.out_pc0, 32'h208);
    step();
    set_group(1'b0, 32'h0);
    chk("b_refull_stall", fb_if.stall_out, 1);
    fb_if.pop_cnt = 2'd2;
    repeat (3) step();
    fb_if.pop_cnt = 2'd0;
    chk("b_fifth_pc0", fb_if.out_pc0, 32'h220);
    chk("b_fifth_pc1", fb_if.out_pc1, 32'h224);

    // Simultaneous push and pop of one
    set_group(1'b1, 32'h300);
    fb_if.pop_cnt = 2'd1;
    step();
    chk("c_head3", fb_if.out_pc0, 32'h224);
    set_group(1'b1, 32'h400);
    step();
    set_group(1'b0, 32'h0);
    fb_if.pop_cnt = 2'd0;
    chk("c_pc0", fb_if.out_pc0, 32'h300);
    chk("c_pc1", fb_if.out_pc1, 32'h304);

    // Flush at count=6 with a group presented
    set_group(1'b1, 32'h500);
    step();
    chk("d_count6_stall", fb_if.stall_out, 0);
    fb_if.flush = 1'b1;
    set_group(1'b1, 32'h600);
    step();
    fb_if.flush = 1'b0;
    set_group(1'b0, 32'h0);
    chk("d_flush_valid0", fb_if.out_valid0, 0);
    chk("d_flush_valid1", fb_if.out_valid1, 0);
    chk("d_flush_stall", fb_if.stall_out, 0);
    step();
    chk("d_group_dropped", fb_if.out_valid0, 0);

    // Flush while full clears stall
    for (int i = 0; i < 4; i++) begin
      set_group(1'b1, 32'h900 + 32'(8 * i));
      step();
    end
    set_group(1'b0, 32'h0);
    chk("d_full_stall", fb_if.stall_out, 1);
    fb_if.flush = 1'b1;
    step();
    fb_if.flush = 1'b0;
    chk("d_full_flush_stall", fb_if.stall_out, 0);

    // Over-pop clipping
    set_group(1'b1, 32'h700);
    step();
    set_group(1'b0, 32'h0);
    fb_if.pop_cnt = 2'd1;
    step();
    chk("e_one_left_pc0", fb_if.out_pc0, 32'h704);
    chk("e_one_left_valid1", fb_if.out_valid1, 0);
    fb_if.pop_cnt = 2'd3;
    step();
    fb_if.pop_cnt = 2'd0;
    chk("e_overpop_valid0", fb_if.out_valid0, 0);
    chk("e_overpop_valid1", fb_if.out_valid1, 0);
    step();
    chk("e_still_empty", fb_if.out_valid0, 0);

    // Steady push/pop across many pointer wraps
    set_group(1'b1, 32'h800);
    step();
    for (int i = 0; i < 20; i++) begin
      set_group(1'b1, 32'h808 + 32'(8 * i));
      fb_if.pop_cnt = 2'd2;
      step();
      chk("f_wrap_pc0", fb_if.out_pc0, 32'h808 + 32'(8 * i));
      chk("f_wrap_pc1", fb_if.out_pc1, 32'h80C + 32'(8 * i));
    end
    set_group(1'b0, 32'h0);
    step();
    fb_if.pop_cnt = 2'd0;
    chk("f_drained", fb_if.out_valid0, 0);

    // pc+4 wraps modulo 2^32
    set_group(1'b1, 32'hFFFF_FFFC);
    step();
    set_group(1'b0, 32'h0);
    chk("g_pc0", fb_if.out_pc0, 32'hFFFF_FFFC);
    chk("g_pc1_wrap", fb_if.out_pc1, 32'h0000_0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
